// File: rtl/hsstl_rx_lane_rst_monitor.sv
// Per-lane RX bring-up supervisor: watches init_done/alos/word-align status,
// issues bounded soft-reset pulses on timeout or sync loss, and latches lane failure.
module hsstl_rx_lane_rst_monitor #(
  parameter int LANE_NUM         = 4,
  parameter int RST_PULSE_CYCLES = 16,
  parameter int DONE_TIMEOUT     = 65535,
  parameter int SYNC_LOSS_CYCLES = 256,
  parameter int MAX_RETRY        = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANE_NUM-1:0]   init_done,
  input  logic [LANE_NUM-1:0]   alos_deb,
  input  logic [LANE_NUM-1:0]   lsm_synced,
  output logic [LANE_NUM-1:0]   rxlane_soft_rst_n,
  output logic [2*LANE_NUM-1:0] lane_state,
  output logic [LANE_NUM-1:0]   lane_fail,
  output logic                  all_done
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_UP   = 2'd1,
    ST_RST  = 2'd2,
    ST_FAIL = 2'd3
  } lane_state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);
  localparam logic [15:0] SYNC_LAST    = 16'(SYNC_LOSS_CYCLES - 1);
  localparam logic [7:0]  PULSE_LAST   = 8'(RST_PULSE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [LANE_NUM-1:0] lane_up;
  logic                all_done_reg;

  generate
    for (genvar gi = 0; gi < LANE_NUM; gi++) begin : g_lane
      lane_state_t state_reg, state_next;
      logic [15:0] timer_reg, timer_next;
      logic [15:0] sync_cnt_reg, sync_cnt_next;
      logic [7:0]  pulse_reg, pulse_next;
      logic [3:0]  retry_reg, retry_next;
      logic        soft_rst_n_reg;
      logic        enter_rst;

      always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        sync_cnt_next = 16'd0;
        pulse_next    = 8'd0;
        retry_next    = retry_reg;
        enter_rst     = 1'b0;
        case (state_reg)
          ST_WAIT: begin
            // init_done takes priority over a coincident timeout
            if (init_done[gi]) begin
              state_next = ST_UP;
              timer_next = 16'd0;
            end else if (alos_deb[gi]) begin
              timer_next = 16'd0;
            end else if (timer_reg == TIMEOUT_LAST) begin
              enter_rst = 1'b1;
            end else begin
              timer_next = sat_inc16(timer_reg);
            end
          end
          ST_UP: begin
            timer_next = sat_inc16(timer_reg);
            if (timer_reg == TIMEOUT_LAST) begin
              retry_next = 4'd0;
            end
            // losing init_done wins over a coincident sync-loss threshold
            if (!init_done[gi]) begin
              state_next = ST_WAIT;
              timer_next = 16'd0;
            end else if (!lsm_synced[gi]) begin
              if (sync_cnt_reg == SYNC_LAST) begin
                enter_rst = 1'b1;
              end else begin
                sync_cnt_next = sat_inc16(sync_cnt_reg);
              end
            end
          end
          ST_RST: begin
            timer_next = 16'd0;
            if (pulse_reg == PULSE_LAST) begin
              state_next = ST_WAIT;
            end else begin
              pulse_next = (pulse_reg == 8'hFF) ? pulse_reg : pulse_reg + 8'd1;
            end
          end
          ST_FAIL: begin
            timer_next = 16'd0;
          end
          default: begin
            state_next = ST_WAIT;
          end
        endcase

        if (enter_rst) begin
          timer_next    = 16'd0;
          sync_cnt_next = 16'd0;
          pulse_next    = 8'd0;
          if (retry_next == RETRY_MAX) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_RST;
            retry_next = (retry_next == 4'hF) ? retry_next : retry_next + 4'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg      <= ST_WAIT;
          timer_reg      <= 16'd0;
          sync_cnt_reg   <= 16'd0;
          pulse_reg      <= 8'd0;
          retry_reg      <= 4'd0;
          soft_rst_n_reg <= 1'b1;
        end else begin
          state_reg      <= state_next;
          timer_reg      <= timer_next;
          sync_cnt_reg   <= sync_cnt_next;
          pulse_reg      <= pulse_next;
          retry_reg      <= retry_next;
          // tracks the next state so the pulse lines up exactly with ST_RST
          soft_rst_n_reg <= (state_next != ST_RST);
        end
      end

      assign rxlane_soft_rst_n[gi]  = soft_rst_n_reg;
      assign lane_state[2*gi +: 2]  = state_reg;
      assign lane_fail[gi]          = (state_reg == ST_FAIL);
      assign lane_up[gi]            = (state_reg == ST_UP);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      all_done_reg <= 1'b0;
    end else begin
      all_done_reg <= &lane_up;
    end
  end

  assign all_done = all_done_reg;

endmodule
